// File: rtl/packed_shift_add_mac_pkg.sv
// Shared constants for the packed shift-add MAC: coefficient field layout
// and the B-term select codes.
package packed_shift_add_mac_pkg;

  localparam int COEF_W       = 6;
  localparam int COEF_SIGN_BIT = 5;
  localparam int COEF_A2_BIT   = 4;  // A = x2, wins over the x16 select
  localparam int COEF_A16_BIT  = 3;  // A = x16
  localparam int COEF_B_HI     = 2;
  localparam int COEF_B_LO     = 1;
  localparam int COEF_C_BIT    = 0;  // C = x1

  typedef enum logic [1:0] {
    B_NONE = 2'b00,
    B_X8   = 2'b01,
    B_X4   = 2'b10,
    B_X32  = 2'b11
  } b_code_e;

endpackage

// File: rtl/packed_shift_add_mac_coef_lane.sv
// coef_shift_add_lane: combinational decode of one 6-bit shift-add coefficient
// and the signed product for one unsigned lane (magnitude up to 49x).
module coef_shift_add_lane
  import packed_shift_add_mac_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0]        i_x,
  input  logic [COEF_W-1:0]        i_coef,
  output logic signed [LANE_W+6:0] o_prod
);

  localparam int MW = LANE_W + 6;

  logic [MW-1:0] w_x;
  logic [MW-1:0] w_a;
  logic [MW-1:0] w_b;
  logic [MW-1:0] w_c;
  logic [MW-1:0] w_mag;
  b_code_e       w_bsel;

  // Sum of up to three shifted copies, then optional negation.
  always_comb begin
    w_x    = MW'(i_x);
    w_bsel = b_code_e'(i_coef[COEF_B_HI:COEF_B_LO]);
    if (i_coef[COEF_A2_BIT])       w_a = w_x << 1;
    else if (i_coef[COEF_A16_BIT]) w_a = w_x << 4;
    else                           w_a = '0;
    case (w_bsel)
      B_X8:    w_b = w_x << 3;
      B_X4:    w_b = w_x << 2;
      B_X32:   w_b = w_x << 5;
      default: w_b = '0;
    endcase
    w_c   = i_coef[COEF_C_BIT] ? w_x : '0;
    w_mag = w_a + w_b + w_c;
    if (i_coef[COEF_SIGN_BIT]) o_prod = -$signed({1'b0, w_mag});
    else                       o_prod =  $signed({1'b0, w_mag});
  end

endmodule

// File: rtl/packed_shift_add_mac.sv
// packed_shift_add_mac: streaming MAC over LANES packed unsigned lanes.
// Pipeline: stage P (products + first/last tags) -> stage A (accumulators)
// -> output register with valid/ready. Everything holds while the output
// is stalled. Define MAC_SATURATE_EN for clamping accumulation with sticky
// per-lane overflow flags; otherwise sums wrap and out_ovf stays 0.
module packed_shift_add_mac
  import packed_shift_add_mac_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int LANE_W = 8,
  parameter int TAPS   = 8,
  parameter int ACC_W  = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic [COEF_W-1:0]       in_coef,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ACC_W-1:0]  out_data,
  output logic [LANES-1:0]        out_ovf
);

  localparam int PW    = LANE_W + 7;
  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic                    w_stall;
  logic                    w_accept;
  logic                    w_tap_last;
  logic [CNT_W-1:0]        r_tap;

  logic signed [PW-1:0]    w_prod    [LANES];
  logic signed [PW-1:0]    r_p_prod  [LANES];
  logic                    r_p_valid;
  logic                    r_p_first;
  logic                    r_p_last;

  logic signed [ACC_W-1:0] r_acc     [LANES];
  logic signed [ACC_W-1:0] w_acc_nxt [LANES];
  logic [LANES-1:0]        w_clamp;
  logic [LANES-1:0]        r_sticky;
  logic                    r_a_done;

  assign w_stall    = out_valid && !out_ready;
  assign in_ready   = !w_stall;
  assign w_accept   = in_valid && in_ready;
  assign w_tap_last = (r_tap == CNT_W'(TAPS - 1));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    coef_shift_add_lane #(.LANE_W(LANE_W)) u_lane (
      .i_x    (in_data[g*LANE_W +: LANE_W]),
      .i_coef (in_coef),
      .o_prod (w_prod[g])
    );
  end

`ifdef MAC_SATURATE_EN
  logic signed [ACC_W:0] w_sum [LANES];

  // Add one bit wider, clamp to the ACC_W signed range on overflow.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_sum[l]     = (ACC_W+1)'(r_acc[l]) + (ACC_W+1)'(r_p_prod[l]);
      w_acc_nxt[l] = w_sum[l][ACC_W-1:0];
      w_clamp[l]   = 1'b0;
      if (w_sum[l][ACC_W] != w_sum[l][ACC_W-1]) begin
        w_clamp[l]   = 1'b1;
        w_acc_nxt[l] = w_sum[l][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
  end
`else
  // Plain modulo-2^ACC_W accumulation, never flags overflow.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_acc_nxt[l] = r_acc[l] + ACC_W'(r_p_prod[l]);
    end
    w_clamp = '0;
  end
`endif

  // Tap counter: position of the next accepted beat within its group.
  always_ff @(posedge clk) begin
    if (!rst_n)          r_tap <= '0;
    else if (w_accept)   r_tap <= w_tap_last ? '0 : r_tap + CNT_W'(1);
  end

  // Stage P: register lane products and group tags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p_valid <= 1'b0;
      r_p_first <= 1'b0;
      r_p_last  <= 1'b0;
      for (int l = 0; l < LANES; l++) r_p_prod[l] <= '0;
    end else if (!w_stall) begin
      r_p_valid <= w_accept;
      r_p_first <= (r_tap == '0);
      r_p_last  <= w_tap_last;
      for (int l = 0; l < LANES; l++) r_p_prod[l] <= w_prod[l];
    end
  end

  // Stage A: first product loads, later ones accumulate; flag group end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sticky <= '0;
      r_a_done <= 1'b0;
      for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
    end else if (!w_stall) begin
      r_a_done <= r_p_valid && r_p_last;
      if (r_p_valid) begin
        if (r_p_first) begin
          r_sticky <= '0;
          for (int l = 0; l < LANES; l++) r_acc[l] <= ACC_W'(r_p_prod[l]);
        end else begin
          r_sticky <= r_sticky | w_clamp;
          for (int l = 0; l < LANES; l++) r_acc[l] <= w_acc_nxt[l];
        end
      end
    end
  end

  // Output register: load a finished group, drop valid once consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= '0;
    end else if (!w_stall) begin
      out_valid <= r_a_done;
      if (r_a_done) begin
        for (int l = 0; l < LANES; l++) out_data[l*ACC_W +: ACC_W] <= r_acc[l];
        out_ovf <= r_sticky;
      end
    end
  end

endmodule

// File: tb/tb_packed_shift_add_mac.sv
// Directed bench for packed_shift_add_mac. Three instances: TAPS=1/ACC_W=20,
// TAPS=4/ACC_W=20 and TAPS=4/ACC_W=15. Expected values follow MAC_SATURATE_EN.
module tb_packed_shift_add_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  iv;
  logic [15:0] in_data;
  logic [5:0]  in_coef;
  logic        out_ready;

  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [39:0] od1;
  logic [39:0] od4;
  logic [29:0] od15;
  logic [1:0]  of1;
  logic [1:0]  of4;
  logic [1:0]  of15;

  int n_tests = 0;
  int n_fail  = 0;
  bit ok;
  bit ok_a;
  bit ok_b;

  always #5 clk = ~clk;

  packed_shift_add_mac #(.LANES(2), .LANE_W(8), .TAPS(1), .ACC_W(20)) u_t1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(in_data), .in_coef(in_coef), .out_valid(ov[0]),
    .out_ready(out_ready), .out_data(od1), .out_ovf(of1));

  packed_shift_add_mac #(.LANES(2), .LANE_W(8), .TAPS(4), .ACC_W(20)) u_t4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(in_data), .in_coef(in_coef), .out_valid(ov[1]),
    .out_ready(out_ready), .out_data(od4), .out_ovf(of4));

  packed_shift_add_mac #(.LANES(2), .LANE_W(8), .TAPS(4), .ACC_W(15)) u_a15 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(in_data), .in_coef(in_coef), .out_valid(ov[2]),
    .out_ready(out_ready), .out_data(od15), .out_ovf(of15));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until accepted; in_ready is sampled
  // mid-cycle so the accepting edge is known exactly.
  task automatic send(input int sel, input logic [15:0] d, input logic [5:0] c, output bit acc);
    bit r;
    in_data = d;
    in_coef = c;
    iv[sel] = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      r = ir[sel];
      @(posedge clk);
      #1;
      if (r) begin
        acc = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int sel, output bit got);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (ov[sel]) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    iv = '0;
    in_data = '0;
    in_coef = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(ov), 64'd0);
    chk("rst_out_data1", 64'(od1), 64'd0);
    chk("rst_out_data15", 64'(od15), 64'd0);
    chk("rst_out_ovf", 64'({of1, of4, of15}), 64'd0);
    chk("rst_in_ready", 64'(ir), 64'h7);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // TAPS=1, x25, latency check
    send(0, 16'h0A03, 6'b001011, ok);
    iv = '0;
    chk("t1_accept", 64'(ok), 64'd1);
    chk("lat_edge_t", 64'(ov[0]), 64'd0);
    @(posedge clk); #1;
    chk("lat_edge_t1", 64'(ov[0]), 64'd0);
    @(posedge clk); #1;
    chk("lat_edge_t2", 64'(ov[0]), 64'd1);
    chk("x25_lane0", 64'(od1[19:0]), 64'd75);
    chk("x25_lane1", 64'(od1[39:20]), 64'd250);
    chk("x25_ovf", 64'(of1), 64'd0);
    @(posedge clk); #1;
    chk("valid_drop", 64'(ov[0]), 64'd0);

    // TAPS=1, -3, sign extension
    send(0, 16'h0102, 6'b110001, ok);
    iv = '0;
    wait_valid(0, ok);
    chk("neg_wait", 64'(ok), 64'd1);
    chk("neg_lane0", 64'(od1[19:0]), 64'(20'hFFFFA));
    chk("neg_lane1", 64'(od1[39:20]), 64'(20'hFFFFD));
    @(posedge clk); #1;

    // TAPS=4, bit4 priority x35
    for (int k = 0; k < 4; k++) begin
      send(1, 16'hFFFF, 6'b011111, ok);
      chk("x35_accept", 64'(ok), 64'd1);
    end
    iv = '0;
    wait_valid(1, ok);
    chk("x35_wait", 64'(ok), 64'd1);
    chk("x35_lane0", 64'(od4[19:0]), 64'd35700);
    chk("x35_lane1", 64'(od4[39:20]), 64'd35700);
    chk("x35_ovf", 64'(of4), 64'd0);
    @(posedge clk); #1;

    // ACC_W=15, x49 overflow
    for (int k = 0; k < 4; k++) begin
      send(2, 16'hFFFF, 6'b001111, ok);
      chk("x49_accept", 64'(ok), 64'd1);
    end
    iv = '0;
    wait_valid(2, ok);
    chk("x49_wait", 64'(ok), 64'd1);
`ifdef MAC_SATURATE_EN
    chk("x49_lane0", 64'(od15[14:0]), 64'(15'h3FFF));
    chk("x49_lane1", 64'(od15[29:15]), 64'(15'h3FFF));
    chk("x49_ovf", 64'(of15), 64'd3);
`else
    chk("x49_lane0", 64'(od15[14:0]), 64'(15'h433C));
    chk("x49_lane1", 64'(od15[29:15]), 64'(15'h433C));
    chk("x49_ovf", 64'(of15), 64'd0);
`endif
    @(posedge clk); #1;

    // Backpressure: group1 x1 of 0x0201 -> 4/8, group2 x8 of 0x0302 -> 64/96
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(1, 16'h0201, 6'b000001, ok);
      chk("bp_g1_accept", 64'(ok), 64'd1);
    end
    fork
      begin
        ok_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
          send(1, 16'h0302, 6'b000010, ok);
          if (!ok) ok_a = 1'b0;
        end
        iv = '0;
      end
      begin
        wait_valid(1, ok_b);
        chk("bp_wait", 64'(ok_b), 64'd1);
        for (int k = 0; k < 5; k++) begin
          chk("bp_valid_hold", 64'(ov[1]), 64'd1);
          chk("bp_in_ready", 64'(ir[1]), 64'd0);
          chk("bp_lane0_stable", 64'(od4[19:0]), 64'd4);
          chk("bp_lane1_stable", 64'(od4[39:20]), 64'd8);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
      end
    join
    chk("bp_g2_accept", 64'(ok_a), 64'd1);
    wait_valid(1, ok);
    chk("bp_g2_wait", 64'(ok), 64'd1);
    chk("bp_g2_lane0", 64'(od4[19:0]), 64'd64);
    chk("bp_g2_lane1", 64'(od4[39:20]), 64'd96);
    @(posedge clk); #1;
    chk("bp_g2_drop", 64'(ov[1]), 64'd0);

    // Reset mid-group discards the partial sum
    for (int k = 0; k < 2; k++) send(1, 16'h0101, 6'b000001, ok);
    iv = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", 64'(ov[1]), 64'd0);
    @(posedge clk); #1;
    chk("mid_rst_valid2", 64'(ov[1]), 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) send(1, 16'h0101, 6'b000001, ok);
    iv = '0;
    wait_valid(1, ok);
    chk("post_rst_wait", 64'(ok), 64'd1);
    chk("post_rst_lane0", 64'(od4[19:0]), 64'd4);
    chk("post_rst_lane1", 64'(od4[39:20]), 64'd4);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
